// File: rtl/inv_key_schedule_128.sv
// Walks an AES-128 key schedule backwards: pops a round-10 key and emits round keys 10 down to 0.
// Latency: the first push comes 1 cycle after the pop; each later round key follows 1 cycle after the previous push.
// Backpressure: out_key_full freezes state, key and round; the next key is popped only in the round-0 push cycle or from IDLE.
module inv_key_schedule_128 #(
  parameter logic [0:255][7:0] look_up_table = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  }
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] in_key,
  output logic         in_key_rd,
  input  logic         in_key_empty,
  output logic [127:0] out_key,
  output logic         out_key_wr,
  input  logic         out_key_full,
  output logic [3:0]   out_round
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t         r_state;
  logic [127:0]   r_key_reg;
  logic [3:0]     r_round;

  logic [31:0]    w_a0, w_a1, w_a2, w_a3;
  logic [31:0]    w_p0, w_p1, w_p2, w_p3;
  logic [127:0]   w_prev_key;
  logic [7:0]     w_rcon;
  logic           w_push;
  logic           w_last;
  logic           w_pop;

  // Round constant that produced the key currently held (round 0 has none).
  always_comb begin
    w_rcon = 8'h00;
    case (r_round)
      4'd10:   w_rcon = 8'h36;
      4'd9:    w_rcon = 8'h1b;
      4'd8:    w_rcon = 8'h80;
      4'd7:    w_rcon = 8'h40;
      4'd6:    w_rcon = 8'h20;
      4'd5:    w_rcon = 8'h10;
      4'd4:    w_rcon = 8'h08;
      4'd3:    w_rcon = 8'h04;
      4'd2:    w_rcon = 8'h02;
      4'd1:    w_rcon = 8'h01;
      default: w_rcon = 8'h00;
    endcase
  end

  // Undo one expansion step; word k sits at bits [32k+31:32k], its first byte lowest.
  always_comb begin
    w_a0 = r_key_reg[31:0];
    w_a1 = r_key_reg[63:32];
    w_a2 = r_key_reg[95:64];
    w_a3 = r_key_reg[127:96];
    w_p3 = w_a3 ^ w_a2;
    w_p2 = w_a2 ^ w_a1;
    w_p1 = w_a1 ^ w_a0;
    // p3 is already the previous key's last word, so RotWord/SubWord can use it directly.
    w_p0[7:0]   = w_a0[7:0]   ^ look_up_table[w_p3[15:8]] ^ w_rcon;
    w_p0[15:8]  = w_a0[15:8]  ^ look_up_table[w_p3[23:16]];
    w_p0[23:16] = w_a0[23:16] ^ look_up_table[w_p3[31:24]];
    w_p0[31:24] = w_a0[31:24] ^ look_up_table[w_p3[7:0]];
    w_prev_key  = {w_p3, w_p2, w_p1, w_p0};
  end

  // FIFO strobes; both are held low while reset is asserted.
  always_comb begin
    w_push = !reset && (r_state == EMIT) && !out_key_full;
    w_last = w_push && (r_round == 4'd0);
    w_pop  = !reset && !in_key_empty && ((r_state == IDLE) || w_last);
  end

  assign in_key_rd  = w_pop;
  assign out_key_wr = w_push;
  assign out_key    = r_key_reg;
  assign out_round  = r_round;

  // Sequencer: load on pop, step back one round per push, chain straight into the next key after round 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_key_reg <= '0;
      r_round   <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_key_reg <= in_key;
            r_round   <= 4'd10;
            r_state   <= EMIT;
          end
        end
        EMIT: begin
          if (w_push) begin
            if (r_round != 4'd0) begin
              r_key_reg <= w_prev_key;
              r_round   <= r_round - 4'd1;
            end else if (w_pop) begin
              r_key_reg <= in_key;
              r_round   <= 4'd10;
            end else begin
              r_state   <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_key_schedule_128.sv
// Directed and scoreboard bench for inv_key_schedule_128.
module tb_inv_key_schedule_128;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [7:0] RC [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  // FIPS-197 Appendix A.1 round keys 0..10, written in the document's byte order.
  localparam logic [127:0] FIPS_BE [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] in_key = '0;
  logic         in_key_empty = 1'b1;
  logic         out_key_full = 1'b0;
  logic         in_key_rd;
  logic [127:0] out_key;
  logic         out_key_wr;
  logic [3:0]   out_round;

  inv_key_schedule_128 dut (
    .clock(clock), .reset(reset), .in_key(in_key), .in_key_rd(in_key_rd),
    .in_key_empty(in_key_empty), .out_key(out_key), .out_key_wr(out_key_wr),
    .out_key_full(out_key_full), .out_round(out_round)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [127:0] src_q[$];
  logic [127:0] cap_key[$];
  logic [3:0]   cap_round[$];
  int           cap_cyc[$];
  logic         cap_rd[$];
  int           pop_cyc[$];
  logic [127:0] exp_key_q[$];
  logic [3:0]   exp_round_q[$];
  logic [127:0] exp_keys [0:10];
  logic         s_rd, s_wr;
  logic [127:0] s_key;
  logic [3:0]   s_round;

  function automatic logic [127:0] bswap(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
    return y;
  endfunction

  // Forward expansion step in the DUT byte order.
  function automatic logic [127:0] fwd_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[31:0]; w1 = k[63:32]; w2 = k[95:64]; w3 = k[127:96];
    t[7:0]   = SBOX[w3[15:8]] ^ rc;
    t[15:8]  = SBOX[w3[23:16]];
    t[23:16] = SBOX[w3[31:24]];
    t[31:24] = SBOX[w3[7:0]];
    n0 = w0 ^ t; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2;
    return {n3, n2, n1, n0};
  endfunction

  task automatic refresh_inputs();
    in_key_empty = (src_q.size() == 0);
    in_key       = (src_q.size() != 0) ? src_q[0] : '0;
  endtask

  task automatic enqueue_key(input logic [127:0] k0);
    exp_keys[0] = k0;
    for (int r = 1; r <= 10; r++) exp_keys[r] = fwd_next(exp_keys[r-1], RC[r]);
    src_q.push_back(exp_keys[10]);
    for (int r = 10; r >= 0; r--) begin
      exp_key_q.push_back(exp_keys[r]);
      exp_round_q.push_back(4'(r));
    end
    refresh_inputs();
  endtask

  task automatic clear_all();
    cap_key.delete(); cap_round.delete(); cap_cyc.delete(); cap_rd.delete();
    pop_cyc.delete(); exp_key_q.delete(); exp_round_q.delete();
  endtask

  // One clock: sample mid-cycle, then apply upstream FIFO effect just after the edge.
  task automatic step();
    @(negedge clock);
    s_rd = in_key_rd; s_wr = out_key_wr; s_key = out_key; s_round = out_round;
    if (s_wr) begin
      cap_key.push_back(s_key); cap_round.push_back(s_round);
      cap_cyc.push_back(cyc); cap_rd.push_back(s_rd);
    end
    if (s_rd) pop_cyc.push_back(cyc);
    @(posedge clock);
    #1;
    cyc++;
    if (s_rd && src_q.size() != 0) void'(src_q.pop_front());
    refresh_inputs();
  endtask

  task automatic test_reset();
    in_key = bswap(FIPS_BE[10]); in_key_empty = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    step();
    n_checks++; if (s_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b want 0", s_rd); end
    n_checks++; if (s_wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b want 0", s_wr); end
    n_checks++; if (s_round !== 4'd0) begin n_fail++; $display("FAIL reset_round: got %0d want 0", s_round); end
    n_checks++; if (s_key !== 128'd0) begin n_fail++; $display("FAIL reset_key: got %h want 0", s_key); end
    reset = 1'b0;
    refresh_inputs();
    step();
    n_checks++; if (s_rd !== 1'b0) begin n_fail++; $display("FAIL post_reset_rd_empty: got %b want 0", s_rd); end
    step();
    n_checks++; if (s_wr !== 1'b0) begin n_fail++; $display("FAIL post_reset_wr: got %b want 0", s_wr); end
  endtask

  task automatic test_fips();
    int budget = 60;
    clear_all();
    src_q.push_back(bswap(FIPS_BE[10]));
    refresh_inputs();
    while (cap_key.size() < 11 && budget > 0) begin step(); budget--; end
    repeat (5) step();
    n_checks++; if (cap_key.size() != 11) begin n_fail++; $display("FAIL fips_push_count: got %0d want 11", cap_key.size()); end
    for (int i = 0; i < cap_key.size() && i < 11; i++) begin
      n_checks++;
      if (cap_round[i] !== 4'(10 - i)) begin n_fail++; $display("FAIL fips_round[%0d]: got %0d want %0d", i, cap_round[i], 10 - i); end
      n_checks++;
      if (cap_key[i] !== bswap(FIPS_BE[10 - i])) begin
        n_fail++; $display("FAIL fips_key r%0d: got %h want %h", 10 - i, cap_key[i], bswap(FIPS_BE[10 - i]));
      end
    end
    n_checks++; if (pop_cyc.size() != 1) begin n_fail++; $display("FAIL fips_pop_count: got %0d want 1", pop_cyc.size()); end
    if (cap_cyc.size() == 11 && pop_cyc.size() >= 1) begin
      n_checks++; if (cap_cyc[0] != pop_cyc[0] + 1) begin n_fail++; $display("FAIL fips_latency: got %0d want 1", cap_cyc[0] - pop_cyc[0]); end
      n_checks++; if (cap_cyc[10] != cap_cyc[0] + 10) begin n_fail++; $display("FAIL fips_span: got %0d want 10", cap_cyc[10] - cap_cyc[0]); end
    end
  endtask

  task automatic test_back_to_back();
    int budget = 80;
    int extra_rd = 0;
    clear_all();
    enqueue_key(bswap(FIPS_BE[0]));
    enqueue_key({$urandom(), $urandom(), $urandom(), $urandom()});
    while (cap_key.size() < 22 && budget > 0) begin step(); budget--; end
    n_checks++; if (cap_key.size() != 22) begin n_fail++; $display("FAIL b2b_push_count: got %0d want 22", cap_key.size()); end
    if (cap_key.size() == 22) begin
      for (int i = 0; i < 22; i++) begin
        n_checks++;
        if (cap_key[i] !== exp_key_q[i] || cap_round[i] !== exp_round_q[i]) begin
          n_fail++; $display("FAIL b2b_key[%0d]: got r%0d %h want r%0d %h", i, cap_round[i], cap_key[i], exp_round_q[i], exp_key_q[i]);
        end
        if (i != 10 && cap_rd[i]) extra_rd++;
      end
      n_checks++; if (cap_cyc[21] != cap_cyc[0] + 21) begin n_fail++; $display("FAIL b2b_gap: got span %0d want 21", cap_cyc[21] - cap_cyc[0]); end
      n_checks++; if (cap_rd[10] !== 1'b1) begin n_fail++; $display("FAIL b2b_round0_rd: got %b want 1", cap_rd[10]); end
      n_checks++; if (extra_rd != 0) begin n_fail++; $display("FAIL b2b_stray_rd: got %0d want 0", extra_rd); end
    end
    n_checks++; if (pop_cyc.size() != 2) begin n_fail++; $display("FAIL b2b_pop_count: got %0d want 2", pop_cyc.size()); end
  endtask

  task automatic test_stall();
    int budget = 80;
    bit stalled = 0;
    int r6 = 0;
    clear_all();
    enqueue_key(bswap(FIPS_BE[0]));
    while (cap_key.size() < 11 && budget > 0) begin
      if (!stalled && out_round == 4'd6 && cap_key.size() == 4) begin
        out_key_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
          step();
          n_checks++; if (s_wr !== 1'b0) begin n_fail++; $display("FAIL stall_wr c%0d: got %b want 0", k, s_wr); end
          n_checks++; if (s_round !== 4'd6) begin n_fail++; $display("FAIL stall_round c%0d: got %0d want 6", k, s_round); end
          n_checks++; if (s_key !== exp_keys[6]) begin n_fail++; $display("FAIL stall_key c%0d: got %h want %h", k, s_key, exp_keys[6]); end
        end
        out_key_full = 1'b0;
        stalled = 1;
      end else begin
        step();
      end
      budget--;
    end
    n_checks++; if (!stalled) begin n_fail++; $display("FAIL stall_reached: got 0 want 1"); end
    n_checks++; if (cap_key.size() != 11) begin n_fail++; $display("FAIL stall_push_count: got %0d want 11", cap_key.size()); end
    for (int i = 0; i < cap_key.size() && i < 11; i++) begin
      if (cap_round[i] == 4'd6) r6++;
      n_checks++;
      if (cap_key[i] !== exp_key_q[i]) begin n_fail++; $display("FAIL stall_key[%0d]: got %h want %h", i, cap_key[i], exp_key_q[i]); end
    end
    n_checks++; if (r6 != 1) begin n_fail++; $display("FAIL stall_r6_pushes: got %0d want 1", r6); end
  endtask

  task automatic test_mid_reset();
    int budget = 40;
    clear_all();
    enqueue_key({$urandom(), $urandom(), $urandom(), $urandom()});
    while (!(out_round == 4'd4 && cap_key.size() != 0) && budget > 0) begin step(); budget--; end
    n_checks++; if (cap_key.size() != 6) begin n_fail++; $display("FAIL mrst_pre_pushes: got %0d want 6", cap_key.size()); end
    clear_all();
    enqueue_key({$urandom(), $urandom(), $urandom(), $urandom()});
    reset = 1'b1;
    step();
    n_checks++; if (s_rd !== 1'b0) begin n_fail++; $display("FAIL mrst_rd: got %b want 0", s_rd); end
    n_checks++; if (s_wr !== 1'b0) begin n_fail++; $display("FAIL mrst_wr: got %b want 0", s_wr); end
    reset = 1'b0;
    step();
    n_checks++; if (s_round !== 4'd0) begin n_fail++; $display("FAIL mrst_round: got %0d want 0", s_round); end
    n_checks++; if (s_rd !== 1'b1) begin n_fail++; $display("FAIL mrst_first_pop: got %b want 1", s_rd); end
    budget = 40;
    while (cap_key.size() < 11 && budget > 0) begin step(); budget--; end
    n_checks++; if (cap_key.size() != 11) begin n_fail++; $display("FAIL mrst_push_count: got %0d want 11", cap_key.size()); end
    if (cap_key.size() == 11) begin
      n_checks++; if (cap_round[0] !== 4'd10 || cap_key[0] !== exp_keys[10]) begin n_fail++; $display("FAIL mrst_first: got r%0d %h want r10 %h", cap_round[0], cap_key[0], exp_keys[10]); end
      n_checks++; if (cap_key[10] !== exp_keys[0]) begin n_fail++; $display("FAIL mrst_last: got %h want %h", cap_key[10], exp_keys[0]); end
    end
  endtask

  task automatic test_idle_empty();
    int budget = 40;
    clear_all();
    refresh_inputs();
    repeat (20) step();
    n_checks++; if (cap_key.size() != 0) begin n_fail++; $display("FAIL empty_pushes: got %0d want 0", cap_key.size()); end
    n_checks++; if (pop_cyc.size() != 0) begin n_fail++; $display("FAIL empty_pops: got %0d want 0", pop_cyc.size()); end
    enqueue_key({$urandom(), $urandom(), $urandom(), $urandom()});
    step();
    n_checks++; if (s_rd !== 1'b1) begin n_fail++; $display("FAIL empty_late_pop: got %b want 1", s_rd); end
    while (cap_key.size() < 11 && budget > 0) begin step(); budget--; end
    n_checks++; if (cap_key.size() != 11) begin n_fail++; $display("FAIL empty_push_count: got %0d want 11", cap_key.size()); end
    if (cap_key.size() == 11) begin
      n_checks++; if (cap_key[10] !== exp_keys[0]) begin n_fail++; $display("FAIL empty_r0_key: got %h want %h", cap_key[10], exp_keys[0]); end
    end
  endtask

  task automatic test_random();
    int budget = 300;
    clear_all();
    for (int n = 0; n < 3; n++) enqueue_key({$urandom(), $urandom(), $urandom(), $urandom()});
    while (cap_key.size() < 33 && budget > 0) begin
      out_key_full = ($urandom_range(0, 3) == 0);
      step();
      budget--;
    end
    out_key_full = 1'b0;
    n_checks++; if (cap_key.size() != 33) begin n_fail++; $display("FAIL rand_push_count: got %0d want 33", cap_key.size()); end
    for (int i = 0; i < cap_key.size() && i < 33; i++) begin
      n_checks++;
      if (cap_key[i] !== exp_key_q[i] || cap_round[i] !== exp_round_q[i]) begin
        n_fail++; $display("FAIL rand_key[%0d]: got r%0d %h want r%0d %h", i, cap_round[i], cap_key[i], exp_round_q[i], exp_key_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_back_to_back();
    test_stall();
    test_mid_reset();
    test_idle_empty();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
